// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: credit-limited instruction prefetch with an in-order response queue and branch redirect.
// Define SISC_FETCH_REL_BR_EN for pc-relative branch targets (br_pc + 1 + br_imm); otherwise br_imm is absolute.
module sisc_fetch_unit #(
    parameter int                ADDR_W  = 16,
    parameter int                INSTR_W = 32,
    parameter int                DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_imm,
    input  logic [ADDR_W-1:0]  br_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   CRED = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [ADDR_W-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d, tgt;
    logic [CW-1:0]      cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic               boot_q, issue, resp, push, pop;
    logic [INSTR_W-1:0] dmem [DEPTH];
    logic [ADDR_W-1:0]  amem [DEPTH];

`ifdef SISC_FETCH_REL_BR_EN
    assign tgt = br_pc + ADDR_W'(1) + br_imm;
`else
    logic unused_br_pc;
    assign unused_br_pc = ^br_pc;
    assign tgt = br_imm;
`endif

    always_comb begin
        imem_req  = rst_f && !boot_q && !br_taken && (({1'b0, cnt_q} + {1'b0, out_q}) < CRED);
        imem_addr = pc_q;
        issue     = imem_req && imem_rdy;
        resp      = imem_rvalid && (out_q != '0);
        push      = resp && (disc_q == '0) && !br_taken;
        ir_valid  = cnt_q != '0;
        ir_data   = ir_valid ? dmem[rd_q] : '0;
        ir_pc     = ir_valid ? amem[rd_q] : '0;
        pop       = ir_valid && ir_ready;
        out_d     = out_q + CW'(issue) - CW'(resp);
        // every request still in flight at a redirect belongs to the old stream
        disc_d    = br_taken ? out_d : disc_q - CW'(resp && (disc_q != '0));
        cnt_d     = br_taken ? '0 : cnt_q + CW'(push) - CW'(pop);
        rd_d      = br_taken ? '0 : pop ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
        wr_d      = br_taken ? '0 : push ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
        pc_d      = br_taken ? tgt : pc_q + ADDR_W'(issue);
        rsp_pc_d  = br_taken ? tgt : rsp_pc_q + ADDR_W'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc_q     <= RST_VEC;
            rsp_pc_q <= RST_VEC;
            cnt_q    <= '0;
            out_q    <= '0;
            disc_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            boot_q   <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            boot_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dmem[wr_q] <= imem_rdata;
            amem[wr_q] <= rsp_pc_q;
        end
    end
endmodule
